// File: rtl/conv_tap_accumulator.sv
// conv_tap_accumulator
// Sums TAPS signed products plus a bias per window, then rounds
// (round-half-up), arithmetic-shifts, saturates and optionally applies ReLU.
// The result appears three cycles after the last-tap input cycle.
//
// Ports:
//   i_clk      clock, rising edge
//   i_reset    synchronous active-high reset
//   i_valid    one tap per asserted cycle
//   i_product  signed product, sampled when i_valid=1
//   i_bias     signed bias in product scale, sampled on tap 0 only
//   i_relu_en  ReLU enable, sampled on the last tap of a window
//   i_flush    discard the partial window (a same-cycle tap becomes tap 0)
//   o_out      signed activation, holds between pulses
//   o_valid    one-cycle pulse per completed window
//   o_sat      clamp occurred for o_out; 0 whenever o_valid=0
module conv_tap_accumulator #(
  parameter int unsigned PROD_WIDTH = 36,
  parameter int unsigned TAPS       = 9,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter int unsigned FRAC_SHIFT = 14,
  parameter int unsigned OUT_WIDTH  = 18
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic [PROD_WIDTH-1:0] i_product,
  input  logic [PROD_WIDTH-1:0] i_bias,
  input  logic                  i_relu_en,
  input  logic                  i_flush,
  output logic [OUT_WIDTH-1:0]  o_out,
  output logic                  o_valid,
  output logic                  o_sat
);

  localparam int unsigned CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int unsigned EXT_W = ACC_WIDTH - PROD_WIDTH;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);
  localparam logic signed [ACC_WIDTH-1:0] RND_HALF = ACC_WIDTH'(1) << (FRAC_SHIFT - 1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
    {{(ACC_WIDTH - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
    {{(ACC_WIDTH - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  // Stage 1: tap accumulation
  logic [CNT_W-1:0]            tap_cnt_q, tap_cnt_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] sum_q, sum_d;
  logic                        sum_v_q, sum_v_d;
  logic                        relu_q, relu_d;
  // Stage 2: round and shift; ReLU enable travels with its window
  logic signed [ACC_WIDTH-1:0] rnd_q, rnd_d;
  logic                        rnd_v_q, rnd_v_d;
  logic                        rnd_relu_q, rnd_relu_d;
  // Stage 3: saturate and ReLU
  logic [OUT_WIDTH-1:0]        out_q, out_d;
  logic                        valid_q, valid_d;
  logic                        sat_q, sat_d;

  // Datapath helpers
  logic [CNT_W-1:0]            cur_cnt;
  logic signed [ACC_WIDTH-1:0] prod_ext, bias_ext, acc_base, acc_next, rnd_sum;
  logic                        ovf_hi, ovf_lo;
  logic [OUT_WIDTH-1:0]        clamped;

  // A flush makes the current tap (if any) tap 0 of a fresh window
  assign cur_cnt  = i_flush ? '0 : tap_cnt_q;
  assign prod_ext = {{EXT_W{i_product[PROD_WIDTH-1]}}, i_product};
  assign bias_ext = {{EXT_W{i_bias[PROD_WIDTH-1]}}, i_bias};
  assign acc_base = (cur_cnt == '0) ? bias_ext : acc_q;
  assign acc_next = acc_base + prod_ext;

  assign rnd_sum  = sum_q + RND_HALF;

  assign ovf_hi   = rnd_q > OUT_MAX;
  assign ovf_lo   = rnd_q < OUT_MIN;
  assign clamped  = ovf_hi ? OUT_MAX[OUT_WIDTH-1:0] :
                    ovf_lo ? OUT_MIN[OUT_WIDTH-1:0] : rnd_q[OUT_WIDTH-1:0];

  // Next-state logic for all three stages
  always_comb begin
    tap_cnt_d  = tap_cnt_q;
    acc_d      = acc_q;
    sum_d      = sum_q;
    sum_v_d    = 1'b0;
    relu_d     = relu_q;
    rnd_d      = rnd_q;
    rnd_v_d    = sum_v_q;
    rnd_relu_d = rnd_relu_q;
    out_d      = out_q;
    valid_d    = rnd_v_q;
    sat_d      = 1'b0;

    if (i_flush) begin
      tap_cnt_d = '0;
    end
    if (i_valid) begin
      if (cur_cnt == LAST_TAP) begin
        tap_cnt_d = '0;
        sum_d     = acc_next;
        sum_v_d   = 1'b1;
        relu_d    = i_relu_en;
      end else begin
        tap_cnt_d = cur_cnt + CNT_W'(1);
        acc_d     = acc_next;
      end
    end

    if (sum_v_q) begin
      rnd_d      = rnd_sum >>> FRAC_SHIFT;
      rnd_relu_d = relu_q;
    end

    if (rnd_v_q) begin
      out_d = (rnd_relu_q && clamped[OUT_WIDTH-1]) ? '0 : clamped;
      sat_d = ovf_hi | ovf_lo;
    end
  end

  // State registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tap_cnt_q  <= '0;
      acc_q      <= '0;
      sum_q      <= '0;
      sum_v_q    <= 1'b0;
      relu_q     <= 1'b0;
      rnd_q      <= '0;
      rnd_v_q    <= 1'b0;
      rnd_relu_q <= 1'b0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      tap_cnt_q  <= tap_cnt_d;
      acc_q      <= acc_d;
      sum_q      <= sum_d;
      sum_v_q    <= sum_v_d;
      relu_q     <= relu_d;
      rnd_q      <= rnd_d;
      rnd_v_q    <= rnd_v_d;
      rnd_relu_q <= rnd_relu_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      sat_q      <= sat_d;
    end
  end

  assign o_out   = out_q;
  assign o_valid = valid_q;
  assign o_sat   = sat_q;

endmodule

// File: tb/tb_conv_tap_accumulator.sv
// Directed bench for conv_tap_accumulator with default parameters.
module tb_conv_tap_accumulator;

  localparam int unsigned PW = 36;
  localparam int unsigned OW = 18;
  localparam int unsigned NTAPS = 9;
  localparam logic signed [PW-1:0] JUNK_BIAS = 36'sd777777;

  logic                 i_clk = 1'b0;
  logic                 i_reset = 1'b1;
  logic                 i_valid = 1'b0;
  logic [PW-1:0]        i_product = '0;
  logic [PW-1:0]        i_bias = '0;
  logic                 i_relu_en = 1'b0;
  logic                 i_flush = 1'b0;
  logic [OW-1:0]        o_out;
  logic                 o_valid;
  logic                 o_sat;

  conv_tap_accumulator dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_valid   (i_valid),
    .i_product (i_product),
    .i_bias    (i_bias),
    .i_relu_en (i_relu_en),
    .i_flush   (i_flush),
    .o_out     (o_out),
    .o_valid   (o_valid),
    .o_sat     (o_sat)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Output capture
  logic signed [OW-1:0] out_q[$];
  logic                 sat_q[$];
  int                   cyc_q[$];
  logic                 sat_leak = 1'b0;
  always @(negedge i_clk) begin
    if (o_valid) begin
      out_q.push_back($signed(o_out));
      sat_q.push_back(o_sat);
      cyc_q.push_back(cyc);
    end else if (o_sat) begin
      sat_leak = 1'b1;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs starting at a falling edge
  task automatic drive(input logic v, input logic signed [PW-1:0] p, input logic signed [PW-1:0] b,
                       input logic relu, input logic flush, input logic rst);
    i_valid   = v;
    i_product = p;
    i_bias    = b;
    i_relu_en = relu;
    i_flush   = flush;
    i_reset   = rst;
    @(negedge i_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Bias only on tap 0 and relu only on the last tap; other taps carry decoys
  task automatic window(input logic signed [PW-1:0] p, input logic signed [PW-1:0] b,
                        input logic relu, input int max_gap, output int last_cyc);
    for (int t = 0; t < NTAPS; t++) begin
      if (t == NTAPS - 1) last_cyc = cyc;
      drive(1'b1, p, (t == 0) ? b : JUNK_BIAS, (t == NTAPS - 1) ? relu : ~relu, 1'b0, 1'b0);
      if (max_gap > 0 && t != NTAPS - 1) idle($urandom_range(0, max_gap));
    end
  endtask

  task automatic clear_q();
    out_q.delete();
    sat_q.delete();
    cyc_q.delete();
  endtask

  task automatic expect_one(input string name, input longint exp_out, input logic exp_sat,
                            input int exp_cyc);
    chk({name, "_count"}, out_q.size(), 1);
    if (out_q.size() >= 1) begin
      chk({name, "_out"}, out_q[0], exp_out);
      chk({name, "_sat"}, sat_q[0], exp_sat);
      chk({name, "_cycle"}, cyc_q[0], exp_cyc);
    end
    clear_q();
  endtask

  typedef struct {
    string                name;
    logic signed [PW-1:0] bias;
    logic signed [PW-1:0] prod;
    logic                 relu;
    logic signed [OW-1:0] exp_out;
    logic                 exp_sat;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int lc, lc_a, lc_b;

    vecs[0]  = '{"unity",    36'sd0,      36'sd16384,       1'b0, 18'sd9,       1'b0};
    vecs[1]  = '{"rnd_p",    36'sd8192,   36'sd0,           1'b0, 18'sd1,       1'b0};
    vecs[2]  = '{"rnd_half", -36'sd8192,  36'sd0,           1'b0, 18'sd0,       1'b0};
    vecs[3]  = '{"rnd_n",    -36'sd8193,  36'sd0,           1'b0, -18'sd1,      1'b0};
    vecs[4]  = '{"rnd_up",   36'sd24575,  36'sd0,           1'b0, 18'sd1,       1'b0};
    vecs[5]  = '{"sat_hi",   36'sd0,      36'sd1073741824,  1'b0, 18'sd131071,  1'b0 | 1'b1};
    vecs[6]  = '{"sat_lo",   36'sd0,      -36'sd1073741824, 1'b0, -18'sd131072, 1'b1};
    vecs[7]  = '{"sat_relu", 36'sd0,      -36'sd1073741824, 1'b1, 18'sd0,       1'b1};
    vecs[8]  = '{"relu_pos", 36'sd0,      36'sd16384,       1'b1, 18'sd9,       1'b0};
    vecs[9]  = '{"neg",      36'sd0,      -36'sd16384,      1'b0, -18'sd9,      1'b0};
    // (100000 + 9*1000 + 8192) >> 14 = 117192 >> 14 = 7
    vecs[10] = '{"mix",      36'sd100000, 36'sd1000,        1'b0, 18'sd7,       1'b0};

    // Reset state
    @(negedge i_clk);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("rst_out", $signed(o_out), 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_sat", o_sat, 0);
    idle(1);
    clear_q();

    // Table-driven windows
    foreach (vecs[i]) begin
      window(vecs[i].prod, vecs[i].bias, vecs[i].relu, 0, lc);
      idle(6);
      expect_one(vecs[i].name, vecs[i].exp_out, vecs[i].exp_sat, lc + 3);
    end

    // Window A with gaps, then B back-to-back
    window(36'sd16384, 36'sd0, 1'b0, 2, lc_a);
    window(-36'sd16384, 36'sd0, 1'b0, 0, lc_b);
    idle(6);
    chk("ab_count", out_q.size(), 2);
    if (out_q.size() == 2) begin
      chk("ab_a_out", out_q[0], 9);
      chk("ab_b_out", out_q[1], -9);
      chk("ab_a_cycle", cyc_q[0], lc_a + 3);
      chk("ab_spacing", cyc_q[1] - cyc_q[0], 9);
    end
    clear_q();

    // Reset mid-window discards the partial sum
    for (int t = 0; t < 5; t++) drive(1'b1, 36'sd16384, 36'sd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    window(36'sd16384, 36'sd0, 1'b0, 0, lc);
    idle(6);
    expect_one("rst_mid", 9, 1'b0, lc + 3);

    // Reset one cycle after a last tap kills that window
    window(-36'sd16384, 36'sd0, 1'b0, 0, lc);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    idle(6);
    chk("rst_after_last_count", out_q.size(), 0);
    chk("rst_after_last_out", $signed(o_out), 0);
    clear_q();

    // Flush with a same-cycle tap restarts the window
    for (int t = 0; t < 4; t++) drive(1'b1, 36'sd16384, 36'sd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 36'sd16384, 36'sd0, 1'b0, 1'b1, 1'b0);
    for (int t = 0; t < 8; t++) begin
      if (t == 7) lc = cyc;
      drive(1'b1, 36'sd16384, JUNK_BIAS, 1'b0, 1'b0, 1'b0);
    end
    idle(6);
    expect_one("flush", 9, 1'b0, lc + 3);

    // Flush after a completed window leaves the in-flight result alone
    window(-36'sd16384, 36'sd0, 1'b0, 0, lc);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    idle(6);
    expect_one("flush_inflight", -9, 1'b0, lc + 3);

    chk("sat_only_with_valid", sat_leak, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
